// File: rtl/ram_arbiter_if.sv
// ram_req_if: one requester's handshake into ram_arbiter (req/we/addr/wdata out, ack/rdata back).
interface ram_req_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (cs/rw, bidirectional data bus) between two requesters.
// Define RAM_ARB_RR_EN for round-robin contention; the default build is fixed priority (port 0 wins).
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_req_if.slave          p0,
  ram_req_if.slave          p1,
  output logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_cs,
  output logic              ram_rw
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_CAP} state_t;

  state_t            state;
  state_t            next_state;
  logic              cand0;
  logic              cand1;
  logic              win_valid;
  logic              win_port;
  logic              drive_en;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              ack0_q;
  logic              ack1_q;
`ifdef RAM_ARB_RR_EN
  logic              prio;
`endif

  // A port whose ack is high this cycle is still holding req from the access just finished.
  assign cand0 = p0.req & ~ack0_q;
  assign cand1 = p1.req & ~ack1_q;

  assign p0.ack   = ack0_q;
  assign p1.ack   = ack1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

  assign ram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    next_state = state;
    win_valid  = 1'b0;
    win_port   = 1'b0;
    case (state)
      IDLE: begin
        if (cand0 || cand1) begin
          win_valid = 1'b1;
`ifdef RAM_ARB_RR_EN
          win_port  = (cand0 && cand1) ? prio : cand1;
`else
          win_port  = ~cand0;
`endif
          next_state = (win_port ? p1.we : p0.we) ? WRITE : READ;
        end
      end
      WRITE:    next_state = IDLE;
      READ:     next_state = READ_CAP;
      READ_CAP: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // RAM strobes decode straight from the state register, so reset drops them at once.
  always_comb begin
    ram_cs   = 1'b0;
    ram_rw   = 1'b0;
    drive_en = 1'b0;
    busy     = (state != IDLE);
    case (state)
      WRITE: begin
        ram_cs   = 1'b1;
        ram_rw   = 1'b1;
        drive_en = 1'b1;
      end
      READ, READ_CAP: ram_cs = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= 1'b0;
      ram_address <= '0;
      wdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      if (win_valid) begin
        grant       <= win_port;
        ram_address <= win_port ? p1.addr  : p0.addr;
        wdata_q     <= win_port ? p1.wdata : p0.wdata;
      end
      if (state == WRITE || state == READ_CAP) begin
        if (grant) ack1_q <= 1'b1;
        else       ack0_q <= 1'b1;
      end
      if (state == READ_CAP) begin
        if (grant) rdata1_q <= ram_data;
        else       rdata0_q <= ram_data;
      end
    end
  end

`ifdef RAM_ARB_RR_EN
  // prio names the port that wins the next tie: always the one not granted last.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       prio <= 1'b0;
    else if (win_valid) prio <= ~win_port;
  end
`endif

endmodule
